// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequenced ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Sequencer-facing bus of the ALU: data bus, A load, op handshake, result and flags.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] bus;
   logic             a_ena;
   logic             op_valid;
   logic [2:0]       op;
   logic             op_ready;
   logic             out_valid;
   logic [WIDTH-1:0] alu_out;
   logic             flag_z;
   logic             flag_n;
   logic             flag_c;
   logic             flag_v;

   modport master (
      output bus, a_ena, op_valid, op,
      input  op_ready, out_valid, alu_out, flag_z, flag_n, flag_c, flag_v
   );

   modport slave (
      input  bus, a_ena, op_valid, op,
      output op_ready, out_valid, alu_out, flag_z, flag_n, flag_c, flag_v
   );
endinterface

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier: one step per clock, WIDTH steps after start.
module alu_mul_iter #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH);

   logic               busy_reg;
   logic [CW-1:0]      cnt_reg;
   logic [WIDTH-1:0]   mcand_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     hi_sum;
   logic [2*WIDTH-1:0] acc_step;

   // Lower half starts as the multiplier and is consumed LSB-first as the sum shifts in.
   assign addend   = acc_reg[0] ? mcand_reg : '0;
   assign hi_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
   assign acc_step = {hi_sum, acc_reg[WIDTH-1:1]};

   // The final step's result is handed out directly so the caller can capture it on the same edge.
   assign done    = busy_reg && (cnt_reg == CW'(WIDTH-1));
   assign product = acc_step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_reg  <= 1'b0;
         cnt_reg   <= '0;
         mcand_reg <= '0;
         acc_reg   <= '0;
      end else if (start) begin
         busy_reg  <= 1'b1;
         cnt_reg   <= '0;
         mcand_reg <= a;
         acc_reg   <= {{WIDTH{1'b0}}, b};
      end else if (busy_reg) begin
         acc_reg <= acc_step;
         cnt_reg <= cnt_reg + 1'b1;
         if (done) begin
            busy_reg <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/alu_seq.sv
// Sequenced ALU: register A, result register G with flags, single-cycle ops plus iterative MUL.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_seq_if.slave   bus_if
);
   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   state_t             state_reg;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   g_reg;
   logic               z_reg, n_reg, c_reg, v_reg;
   logic               out_valid_reg;

   logic               accept;
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;
   logic [WIDTH:0]     sum_ext;
   logic [WIDTH:0]     diff_ext;
   logic [WIDTH-1:0]   res_next;
   logic               c_next, v_next;

   assign accept    = bus_if.op_valid && (state_reg == ST_IDLE);
   assign mul_start = accept && (bus_if.op == OP_MUL);

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a_reg),
      .b       (bus_if.bus),
      .done    (mul_done),
      .product (mul_product)
   );

   assign sum_ext  = {1'b0, a_reg} + {1'b0, bus_if.bus};
   assign diff_ext = {1'b0, a_reg} - {1'b0, bus_if.bus};

   always_comb begin
      res_next = '0;
      c_next   = 1'b0;
      v_next   = 1'b0;
      case (bus_if.op)
         OP_ADD: begin
            res_next = sum_ext[WIDTH-1:0];
            c_next   = sum_ext[WIDTH];
            v_next   = (a_reg[MSB] == bus_if.bus[MSB]) && (res_next[MSB] != a_reg[MSB]);
         end
         OP_SUB: begin
            // The extra top bit of the widened difference is the unsigned borrow.
            res_next = diff_ext[WIDTH-1:0];
            c_next   = diff_ext[WIDTH];
            v_next   = (a_reg[MSB] != bus_if.bus[MSB]) && (res_next[MSB] != a_reg[MSB]);
         end
         OP_AND:  res_next = a_reg & bus_if.bus;
         OP_OR:   res_next = a_reg | bus_if.bus;
         OP_XOR:  res_next = a_reg ^ bus_if.bus;
         OP_SHL:  res_next = a_reg << bus_if.bus[SHW-1:0];
         default: res_next = bus_if.bus;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         a_reg         <= '0;
         g_reg         <= '0;
         z_reg         <= 1'b0;
         n_reg         <= 1'b0;
         c_reg         <= 1'b0;
         v_reg         <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         out_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (bus_if.a_ena) begin
                  a_reg <= bus_if.bus;
               end
               if (accept) begin
                  if (bus_if.op == OP_MUL) begin
                     state_reg <= ST_BUSY;
                  end else begin
                     g_reg         <= res_next;
                     z_reg         <= (res_next == '0);
                     n_reg         <= res_next[MSB];
                     c_reg         <= c_next;
                     v_reg         <= v_next;
                     out_valid_reg <= 1'b1;
                  end
               end
            end
            default: begin
               if (mul_done) begin
                  g_reg         <= mul_product[WIDTH-1:0];
                  z_reg         <= (mul_product[WIDTH-1:0] == '0);
                  n_reg         <= mul_product[MSB];
                  c_reg         <= |mul_product[2*WIDTH-1:WIDTH];
                  v_reg         <= 1'b0;
                  out_valid_reg <= 1'b1;
                  state_reg     <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign bus_if.op_ready  = (state_reg == ST_IDLE);
   assign bus_if.out_valid = out_valid_reg;
   assign bus_if.alu_out   = g_reg;
   assign bus_if.flag_z    = z_reg;
   assign bus_if.flag_n    = n_reg;
   assign bus_if.flag_c    = c_reg;
   assign bus_if.flag_v    = v_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16) with an arithmetic reference model.
module tb_alu_seq;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   logic [15:0] a_model = '0;

   alu_seq_if #(.WIDTH(16)) ifc ();

   alu_seq #(.WIDTH(16)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (ifc.slave)
   );

   always #5 clk = ~clk;

   // Returns {G[15:0], z, n, c, v} computed from plain integer arithmetic.
   function automatic logic [19:0] ref_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
      longint ua, ub, full;
      int sa, sb, s;
      logic [15:0] g;
      logic c, v;
      ua = longint'(a); ub = longint'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      c = 1'b0; v = 1'b0; full = 0; s = 0;
      case (o)
         OP_ADD: begin full = ua + ub; c = (full >= 65536); s = sa + sb; v = (s > 32767) || (s < -32768); end
         OP_SUB: begin full = ua - ub + 65536; c = (ua < ub); s = sa - sb; v = (s > 32767) || (s < -32768); end
         OP_AND: full = ua & ub;
         OP_OR:  full = ua | ub;
         OP_XOR: full = ua ^ ub;
         OP_SHL: full = ua * (64'd1 << (ub % 16));
         OP_MUL: begin full = ua * ub; c = ((full / 65536) != 0); end
         default: full = ub;
      endcase
      g = full[15:0];
      return {g, (g == 16'd0), g[15], c, v};
   endfunction

   task automatic load_a(input logic [15:0] val);
      ifc.a_ena = 1'b1; ifc.bus = val;
      @(posedge clk); #1;
      ifc.a_ena = 1'b0;
      a_model = val;
   endtask

   // Issues one op from IDLE and waits (bounded) for out_valid; lat = edges until it is seen.
   task automatic send(input logic [2:0] o, input logic [15:0] b, input logic ae, output int lat);
      ifc.op = o; ifc.bus = b; ifc.a_ena = ae; ifc.op_valid = 1'b1;
      @(posedge clk); #1;
      ifc.op_valid = 1'b0; ifc.a_ena = 1'b0;
      lat = 1;
      while (!ifc.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      $display("op=%0d b=%h ae=%0d lat=%0d g=%h zncv=%b%b%b%b", o, b, ae, lat, ifc.alu_out,
               ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if ({ifc.alu_out, ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v, ifc.op_ready, ifc.out_valid} !== {16'h0, 4'b0, 1'b1, 1'b0})
         $display("FAIL reset: got g=%h zncv=%b%b%b%b rdy=%b ov=%b, want 0000/0000/1/0", ifc.alu_out,
                  ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v, ifc.op_ready, ifc.out_valid);
      else pass_cnt++;
      rst_n = 1'b1;
      a_model = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_add_overflow();
      int lat;
      load_a(16'h7FFF);
      send(OP_ADD, 16'h0001, 1'b0, lat);
      total_cnt++;
      if (lat !== 1) $display("FAIL add_latency: got %0d want 1", lat); else pass_cnt++;
      total_cnt++;
      if ({ifc.alu_out, ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v} !== {16'h8000, 4'b0101})
         $display("FAIL add_ovf: got %h/%b%b%b%b want 8000/0101", ifc.alu_out, ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (ifc.out_valid !== 1'b0) $display("FAIL add_pulse: out_valid got %b want 0", ifc.out_valid); else pass_cnt++;
   endtask

   task automatic test_sub_xor();
      int lat;
      load_a(16'h0003);
      send(OP_SUB, 16'h0005, 1'b0, lat);
      total_cnt++;
      if ({ifc.alu_out, ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v} !== {16'hFFFE, 4'b0110})
         $display("FAIL sub_borrow: got %h/%b%b%b%b want fffe/0110", ifc.alu_out, ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v);
      else pass_cnt++;
      send(OP_XOR, 16'h0003, 1'b0, lat);
      total_cnt++;
      if ({ifc.alu_out, ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v} !== {16'h0000, 4'b1000})
         $display("FAIL xor_zero: got %h/%b%b%b%b want 0000/1000", ifc.alu_out, ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v);
      else pass_cnt++;
   endtask

   task automatic test_mul();
      int lo, early, lat;
      load_a(16'h0123);
      ifc.op = OP_MUL; ifc.bus = 16'h0100; ifc.op_valid = 1'b1;
      @(posedge clk); #1;
      // Hold a PASS request and poke a_ena while busy; neither may take effect yet.
      ifc.op = OP_PASS; ifc.bus = 16'h5A5A; ifc.a_ena = 1'b1;
      lo = 0; early = 0;
      while (!ifc.op_ready && lo < 40) begin
         lo++;
         if (ifc.out_valid) early++;
         if (lo == 8) ifc.a_ena = 1'b0;
         @(posedge clk); #1;
      end
      ifc.a_ena = 1'b0;
      total_cnt++;
      if (lo !== 16) $display("FAIL mul_busy_len: got %0d want 16", lo); else pass_cnt++;
      total_cnt++;
      if (early !== 0) $display("FAIL mul_early_valid: got %0d want 0", early); else pass_cnt++;
      total_cnt++;
      if ({ifc.out_valid, ifc.alu_out, ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v} !== {1'b1, 16'h2300, 4'b0010})
         $display("FAIL mul_result: got ov=%b %h/%b%b%b%b want 1 2300/0010", ifc.out_valid, ifc.alu_out,
                  ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v);
      else pass_cnt++;
      @(posedge clk); #1;
      ifc.op_valid = 1'b0;
      total_cnt++;
      if ({ifc.out_valid, ifc.alu_out, ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v} !== {1'b1, 16'h5A5A, 4'b0000})
         $display("FAIL held_pass: got ov=%b %h/%b%b%b%b want 1 5a5a/0000", ifc.out_valid, ifc.alu_out,
                  ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v);
      else pass_cnt++;
      @(posedge clk); #1;
      send(OP_ADD, 16'h0000, 1'b0, lat);
      total_cnt++;
      if (ifc.alu_out !== 16'h0123) $display("FAIL busy_a_ena: A got %h want 0123", ifc.alu_out); else pass_cnt++;
   endtask

   task automatic test_same_edge();
      int lat;
      load_a(16'h0001);
      send(OP_ADD, 16'h0010, 1'b1, lat);
      total_cnt++;
      if (ifc.alu_out !== 16'h0011) $display("FAIL same_edge_old_a: got %h want 0011", ifc.alu_out); else pass_cnt++;
      send(OP_ADD, 16'h0000, 1'b0, lat);
      total_cnt++;
      if (ifc.alu_out !== 16'h0010) $display("FAIL same_edge_new_a: got %h want 0010", ifc.alu_out); else pass_cnt++;
      a_model = 16'h0010;
   endtask

   task automatic test_reset_mid_mul();
      int lat, seen;
      load_a(16'h1234);
      ifc.op = OP_MUL; ifc.bus = 16'h00FF; ifc.op_valid = 1'b1;
      @(posedge clk); #1;
      ifc.op_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({ifc.alu_out, ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v, ifc.op_ready, ifc.out_valid} !== {16'h0, 4'b0, 1'b1, 1'b0})
         $display("FAIL abort_reset: got g=%h zncv=%b%b%b%b rdy=%b ov=%b want 0000/0000/1/0", ifc.alu_out,
                  ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v, ifc.op_ready, ifc.out_valid);
      else pass_cnt++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      a_model = '0;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (ifc.out_valid || !ifc.op_ready) seen++;
      end
      total_cnt++;
      if (seen !== 0 || ifc.alu_out !== 16'h0)
         $display("FAIL abort_quiet: got %0d stray cycles, g=%h want 0, 0000", seen, ifc.alu_out);
      else pass_cnt++;
      load_a(16'h0001);
      send(OP_SHL, 16'h000F, 1'b0, lat);
      total_cnt++;
      if ({ifc.alu_out, ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v} !== {16'h8000, 4'b0100})
         $display("FAIL shl_after_abort: got %h/%b%b%b%b want 8000/0100", ifc.alu_out, ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [2:0]  o;
      logic [15:0] b;
      logic [19:0] exp;
      ifc.op_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         o = 3'($urandom_range(0, 5));
         if (o == OP_MUL) o = OP_PASS;
         b = 16'($urandom);
         if (o == OP_SHL && i == 0) b = 16'h0000;
         ifc.op = o; ifc.bus = b;
         exp = ref_op(o, a_model, b);
         @(posedge clk); #1;
         $display("b2b op=%0d b=%h g=%h", o, b, ifc.alu_out);
         total_cnt++;
         if ({ifc.out_valid, ifc.alu_out, ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v} !== {1'b1, exp})
            $display("FAIL b2b_%0d: got ov=%b %h/%b%b%b%b want 1 %h/%b", i, ifc.out_valid, ifc.alu_out,
                     ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v, exp[19:4], exp[3:0]);
         else pass_cnt++;
      end
      ifc.op_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [15:0] b;
      logic        ae;
      logic [19:0] exp;
      int lat, want_lat;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) load_a(16'($urandom));
         o  = 3'($urandom_range(0, 7));
         b  = 16'($urandom);
         if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 3));
         ae = ($urandom_range(0, 3) == 0);
         exp = ref_op(o, a_model, b);
         want_lat = (o == OP_MUL) ? 17 : 1;
         send(o, b, ae, lat);
         if (ae) a_model = b;
         total_cnt++;
         if (lat !== want_lat || {ifc.alu_out, ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v} !== exp)
            $display("FAIL rand_%0d op=%0d: got lat=%0d %h/%b%b%b%b want lat=%0d %h/%b", i, o, lat, ifc.alu_out,
                     ifc.flag_z, ifc.flag_n, ifc.flag_c, ifc.flag_v, want_lat, exp[19:4], exp[3:0]);
         else pass_cnt++;
      end
   endtask

   initial begin
      ifc.bus = '0; ifc.a_ena = 1'b0; ifc.op_valid = 1'b0; ifc.op = OP_ADD;
      test_reset();
      test_add_overflow();
      test_sub_xor();
      test_mul();
      test_same_edge();
      test_reset_mid_mul();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
